// File: rtl/frame_loader.sv
// frame_loader
// Takes a valid/ready byte stream and waits for a SYNC byte. It then collects
// the next 48 colour bytes into a shadow buffer. On the LED driver's vsync
// pulse it copies the whole shadow buffer to `values`, so the display never
// shows half of one frame and half of another.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   in_data     stream byte
//   in_valid    in_data is valid
//   in_ready    loader can accept a byte (low only while a frame waits for vsync)
//   vsync       one-cycle end-of-scan pulse from the LED driver
//   values      committed frame, LED j = {R,G,B} at [24j+23:24j]
//   frame_done  one-cycle pulse when a frame is committed
//   abort       one-cycle pulse when a partial frame is dropped on idle timeout
//
// state   | meaning
// HUNT    | discard bytes until SYNC is accepted
// LOAD    | store colour bytes k = 0..47 into the shadow buffer, watch idle time
// PENDING | full frame in shadow, stall input until vsync commits it
module frame_loader #(
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int         TIMEOUT = 50000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         vsync,
  output logic [383:0] values,
  output logic         frame_done,
  output logic         abort
);

  localparam int             CW        = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  IDLE_LAST = CW'(TIMEOUT - 1);
  localparam logic [5:0]     K_LAST    = 6'd47;

  typedef enum logic [1:0] {HUNT, LOAD, PENDING} state_t;

  state_t           state;
  logic [5:0]       k;
  logic [CW-1:0]    idle_cnt;
  logic [47:0][7:0] shadow;

  logic             accept;
  logic [5:0]       led;
  logic [5:0]       comp;
  logic [5:0]       slot;

  assign in_ready = (state != PENDING);
  assign accept   = in_valid && in_ready;

  // Red is the most significant byte of each LED's 24-bit field.
  // Byte k therefore lands in packed slot 3*led + (2 - comp).
  always_comb begin
    led  = k / 6'd3;
    comp = k - 6'd3 * led;
    slot = 6'd3 * led + 6'd2 - comp;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= HUNT;
      k          <= '0;
      idle_cnt   <= '0;
      shadow     <= '0;
      values     <= '0;
      frame_done <= 1'b0;
      abort      <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      abort      <= 1'b0;
      case (state)
        HUNT: begin
          if (accept && in_data == SYNC) begin
            state    <= LOAD;
            k        <= '0;
            idle_cnt <= '0;
          end
        end
        LOAD: begin
          // An accept on the same edge as the timeout takes priority.
          if (accept) begin
            shadow[slot] <= in_data;
            idle_cnt     <= '0;
            if (k == K_LAST) begin
              state <= PENDING;
              k     <= '0;
            end else begin
              k <= k + 6'd1;
            end
          end else if (idle_cnt == IDLE_LAST) begin
            // The shadow buffer is left as it is; the next frame overwrites it.
            state    <= HUNT;
            abort    <= 1'b1;
            k        <= '0;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + CW'(1);
          end
        end
        PENDING: begin
          if (vsync) begin
            values     <= shadow;
            frame_done <= 1'b1;
            state      <= HUNT;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_loader.sv
module tb_frame_loader;

  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic         vsync;
  logic [383:0] values;
  logic         frame_done;
  logic         abort;

  frame_loader #(.SYNC(8'hA5), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .vsync(vsync), .values(values),
    .frame_done(frame_done), .abort(abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         njunk;
    int         a5_pos;
    logic [7:0] base;
    bit         coinc;
    bit         pre_abort;
    logic [23:0] led0;
    logic [23:0] led1;
    logic [23:0] led15;
  } vec_t;

  vec_t         tbl[4];
  int           checks   = 0;
  int           failures = 0;
  int           done_cnt = 0;
  int           abort_cnt = 0;
  logic [383:0] exp_q[$];
  logic [383:0] committed_model = '0;
  logic [7:0]   fb[48];

  // Scoreboard: each committed frame must match the oldest expected frame.
  always @(negedge clk) begin
    logic [383:0] e;
    if (frame_done) begin
      done_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_commit values=%h", values);
      end else begin
        e = exp_q.pop_front();
        if (values !== e) begin
          failures++;
          $display("FAIL sb_frame got=%h exp=%h", values, e);
        end
        committed_model = e;
      end
    end
    if (abort) abort_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [383:0] got, input logic [383:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [383:0] model_frame();
    logic [383:0] r;
    r = '0;
    for (int i = 0; i < 48; i++)
      r[24*(i/3) + 23 - 8*(i%3) -: 8] = fb[i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit vs_with);
    int n;
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_stall got=in_ready_low exp=in_ready_high");
    end
    vsync = vs_with;
    tick();
    in_valid = 1'b0;
    vsync    = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base, input int a5_pos, input bit coinc);
    send_byte(8'hA5, 1'b0);
    for (int i = 0; i < 48; i++) begin
      fb[i] = (i == a5_pos) ? 8'hA5 : base + 8'(i);
      send_byte(fb[i], coinc && i == 47);
    end
  endtask

  task automatic do_abort();
    int n;
    int a0;
    send_byte(8'hA5, 1'b0);
    for (int i = 0; i < 10; i++) send_byte(8'h70 + 8'(i), 1'b0);
    a0 = abort_cnt;
    n  = 0;
    while (!abort && n < 40) begin
      tick();
      n++;
    end
    check("abort_latency", 384'(n), 384'(TO));
    check("ready_after_abort", 384'(in_ready), 384'(1));
    check("values_kept_on_abort", values, committed_model);
    tick();
    check("abort_one_cycle", 384'(abort), 384'(0));
    check("abort_count", 384'(abort_cnt), 384'(a0 + 1));
  endtask

  task automatic run_case(input vec_t v);
    int d0;
    if (v.pre_abort) do_abort();
    for (int j = 0; j < v.njunk; j++) send_byte((j == 0) ? 8'h11 : 8'h22, 1'b0);
    send_frame(v.base, v.a5_pos, v.coinc);
    exp_q.push_back(model_frame());
    check("ready_low_after_47", 384'(in_ready), 384'(0));
    d0 = done_cnt;
    repeat (20) tick();
    check("values_held_pending", values, committed_model);
    check("no_early_done", 384'(done_cnt), 384'(d0));
    check("ready_low_pending", 384'(in_ready), 384'(0));
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    check("frame_done_high", 384'(frame_done), 384'(1));
    check("led0", 384'(values[23:0]), 384'(v.led0));
    check("led1", 384'(values[47:24]), 384'(v.led1));
    check("led15", 384'(values[383:360]), 384'(v.led15));
    check("ready_after_commit", 384'(in_ready), 384'(1));
    tick();
    check("frame_done_one_cycle", 384'(frame_done), 384'(0));
  endtask

  initial begin
    tbl[0] = '{0, -1, 8'h00, 1'b0, 1'b0, 24'h000102, 24'h030405, 24'h2D2E2F};
    tbl[1] = '{2,  4, 8'h40, 1'b0, 1'b0, 24'h404142, 24'h43A545, 24'h6D6E6F};
    tbl[2] = '{0, -1, 8'h80, 1'b1, 1'b0, 24'h808182, 24'h838485, 24'hADAEAF};
    tbl[3] = '{0, -1, 8'hC0, 1'b0, 1'b1, 24'hC0C1C2, 24'hC3C4C5, 24'hEDEEEF};

    rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; vsync = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("reset_values", values, '0);
    check("reset_ready", 384'(in_ready), 384'(1));
    check("reset_frame_done", 384'(frame_done), 384'(0));
    check("reset_abort", 384'(abort), 384'(0));
    repeat (1000) tick();
    check("idle_no_done", 384'(done_cnt), 384'(0));
    check("idle_no_abort", 384'(abort_cnt), 384'(0));
    check("idle_values", values, '0);

    for (int i = 0; i < 4; i++) run_case(tbl[i]);

    // Reset mid-LOAD: outputs clear at once, without waiting for a clock edge.
    send_byte(8'hA5, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(8'h33, 1'b0);
    #3 rst = 1'b0;
    #1;
    check("rst_load_values", values, '0);
    check("rst_load_ready", 384'(in_ready), 384'(1));
    committed_model = '0;
    tick();
    rst = 1'b1;
    tick();
    run_case(tbl[0]);

    // Reset while a full frame waits in PENDING.
    send_frame(8'h50, -1, 1'b0);
    check("pending_ready_low", 384'(in_ready), 384'(0));
    #3 rst = 1'b0;
    #1;
    check("rst_pend_values", values, '0);
    check("rst_pend_ready", 384'(in_ready), 384'(1));
    committed_model = '0;
    tick();
    rst = 1'b1;
    tick();
    run_case(tbl[1]);

    check("sb_drained", 384'(exp_q.size()), 384'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_loader.md
# frame_loader

Serial-to-frame loader feeding the 16-LED RGB matrix driver. Accepts a byte stream with valid/ready handshake, hunts for a sync byte, assembles the following 48 colour bytes into a shadow buffer, then commits the whole frame to the 384-bit `values` bus on the driver's `vsync` pulse so the display never shows a torn frame. Sits between the serial byte receiver and the LED driver.

## Interface
- `SYNC`, 8'hA5: start-of-frame marker byte.
- `TIMEOUT`, 50000: max idle cycles between bytes inside a frame before abort (≥2).
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: reset; asynchronous, active-low.
- `in_data` in 8: stream byte.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: loader can accept; a byte transfers on an edge where `in_valid && in_ready`.
- `vsync` in 1: one-cycle pulse from the LED driver at end of its scan period.
- `values` out 384: committed frame; LED j red `[24j+23:24j+16]`, green `[24j+15:24j+8]`, blue `[24j+7:24j]`.
- `frame_done` out 1: one-cycle pulse, frame committed.
- `abort` out 1: one-cycle pulse, partial frame dropped on timeout.

## Operation
- States: HUNT, LOAD, PENDING. Reset → HUNT.
- HUNT: `in_ready`=1. Accepted byte == `SYNC` → LOAD, byte index k=0, idle counter=0. Any other byte discarded, stay HUNT. `vsync` ignored.
- LOAD: `in_ready`=1. Accepted byte k (0..47) written to shadow: LED j=k/3, component c=k mod 3 (0=R,1=G,2=B) → shadow bits `[24j+23-8c : 24j+16-8c]`. Value `SYNC` is ordinary data here (no resync). Byte k=47 accepted → PENDING. `vsync` ignored.
- LOAD idle counter: cleared on every accepted byte, else increments. Counter reaching `TIMEOUT`-1 with no accept that cycle → HUNT, `abort` pulse, k=0; shadow contents left as-is (overwritten by next frame). Accept and timeout on same edge: accept wins.
- PENDING: `in_ready`=0 (backpressure). `vsync` sampled high → `values` ← shadow, `frame_done` pulse, → HUNT.
- `values` changes only on commit; partial or aborted frames never reach it.
- k: 6-bit, never exceeds 47. Idle counter width `$clog2(TIMEOUT)`, saturates not wraps.
- Reset mid-operation (any state): immediate HUNT, k=0, counter=0, shadow=0, `values`=0.

## Timing
- Reset values: `values`=0, `in_ready`=1 (HUNT), `frame_done`=0, `abort`=0.
- `in_ready` is a registered-state decode: deasserts in the cycle after the edge accepting byte 47; reasserts the cycle after commit edge.
- Commit: `vsync` high before edge N in PENDING → `values` new and `frame_done`=1 during cycle after N; `frame_done` low one cycle later.
- `vsync` high on the same edge byte 47 is accepted: no commit; waits for next `vsync` (one driver scan period later).
- Minimum latency SYNC accept → `frame_done`: 49 accepting edges + wait for `vsync`.
- `abort` high the cycle after the timeout edge, one cycle wide.
- `in_valid` may be held through backpressure; held byte transfers on first cycle back in HUNT (treated as HUNT byte).

## Test plan
- Reset then `in_valid` idle → `values`=0, `in_ready`=1, no pulses for 1000 cycles.
- Send A5 then bytes 0x00..0x2F back-to-back, `vsync` pulse 20 cycles later → `in_ready` low from after byte 0x2F until commit; `values[23:0]`=0x000102, `values[383:360]`=0x2D2E2F; `frame_done` one cycle; `values` unchanged before `vsync`.
- Junk 0x11,0x22 before A5, and 0xA5 used as data byte 5 → junk ignored, LED1 green = 0xA5, frame commits normally.
- `TIMEOUT`=16: A5 + 10 bytes, then idle 16 cycles → `abort` one cycle, state HUNT; previous `values` retained; following full frame commits correctly.
- `vsync` coincident with byte 47 acceptance → no `frame_done`; commit on next `vsync` only.
- Assert `rst` low asynchronously mid-LOAD and in PENDING → `values`=0, `in_ready`=1 immediately; fresh frame afterwards loads and commits.
